// File: rtl/vga_img_pkg.sv
// Shared types and constants for the VGA image-window path.
// Build option: VGA_IMG_BOUNCE_EN (window bounces around the screen) is
// consumed by vga_img_window_ctrl; nothing in this package depends on it.
package vga_img_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t RED   = 16'hF800;
  localparam rgb565_t GREEN = 16'h07E0;
  localparam rgb565_t BLUE  = 16'h001F;

  typedef enum logic {POS = 1'b0, NEG = 1'b1} axis_dir_t;

  // True when p lies in [lo, lo+len); 11 bits so lo+len cannot wrap on screen.
  function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/vga_img_window_ctrl_if.sv
// Image ROM read bus: the window controller is the master, the ROM the slave.
interface vga_img_window_ctrl_if
  import vga_img_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  rgb565_t           rom_data;

  modport master (output rom_rd_en, output rom_addr, input  rom_data);
  modport slave  (input  rom_rd_en, input  rom_addr, output rom_data);
endinterface

// File: rtl/vga_img_bounce_axis.sv
// One axis of the bouncing window: origin register plus POS/NEG direction FSM.
// Advances only on frame_end, so the origin is stable for a whole frame.
module vga_img_bounce_axis
  import vga_img_pkg::*;
#(
  parameter int LIM  = 540,
  parameter int STEP = 1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       frame_end,
  output logic [9:0] org
);
  localparam logic [10:0] LIM_W  = 11'(LIM);
  localparam logic [10:0] STEP_W = 11'(STEP);

  axis_dir_t   dir;
  logic [10:0] org_ext;

  assign org_ext = {1'b0, org};

  // Step the origin once per frame, clamping to and reversing at either edge.
  always_ff @(posedge sys_clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
    if (!rst_n) begin
      org <= '0;
      dir <= POS;
    end else if (frame_end) begin
      unique case (dir)
        POS: begin
          if (org_ext + STEP_W >= LIM_W) begin
            org <= LIM_W[9:0];
            dir <= NEG;
          end else begin
            org <= 10'(org_ext + STEP_W);
          end
        end
        NEG: begin
          if (org_ext <= STEP_W) begin
            org <= '0;
            dir <= POS;
          end else begin
            org <= 10'(org_ext - STEP_W);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_img_window_ctrl.sv
// Image-window sequencer: window compare, linear ROM address counter, hit delay
// line aligned to ROM latency, and the registered RGB565 mux.
// Pixel-to-rgb latency is fixed at ROM_LAT+2 cycles.
// Build option: VGA_IMG_BOUNCE_EN -- when defined the origin bounces one STEP per
// frame starting at (0,0); when undefined the origin is fixed at (X0,Y0).
module vga_img_window_ctrl
  import vga_img_pkg::*;
#(
  parameter int      H_DISP   = H_DISP_DEF,
  parameter int      V_DISP   = V_DISP_DEF,
  parameter int      IMG_W    = 100,
  parameter int      IMG_H    = 100,
  parameter int      ADDR_W   = 14,
  parameter int      ROM_LAT  = 1,
  parameter int      STEP     = 1,
  parameter int      X0       = 270,
  parameter int      Y0       = 190,
  parameter rgb565_t BG_COLOR = BLACK
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  pix_valid,
  input  logic                  frame_end,
  vga_img_window_ctrl_if.master rom,
  output rgb565_t               rgb
);
  localparam int              IMG_PIX   = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_PIX - 1);

  localparam bit CFG_OK = (ROM_LAT >= 1) && (ROM_LAT <= 3) && (STEP >= 1) &&
                          ((64'd1 << ADDR_W) >= 64'(IMG_PIX)) &&
                          (X0 + IMG_W <= H_DISP) && (Y0 + IMG_H <= V_DISP);

  if (!CFG_OK) begin : g_cfg_err
    $error("vga_img_window_ctrl: inconsistent parameter set");
  end

  logic [9:0]        org_x;
  logic [9:0]        org_y;
  logic              hit;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [ROM_LAT:0]  hit_pipe;
  logic              hit_d;

`ifdef VGA_IMG_BOUNCE_EN
  vga_img_bounce_axis #(.LIM(H_DISP - IMG_W), .STEP(STEP)) u_axis_x (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .frame_end (frame_end),
    .org       (org_x)
  );

  vga_img_bounce_axis #(.LIM(V_DISP - IMG_H), .STEP(STEP)) u_axis_y (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .frame_end (frame_end),
    .org       (org_y)
  );
`else
  assign org_x = 10'(X0);
  assign org_y = 10'(Y0);
`endif

  assign hit = pix_valid &&
               in_span({1'b0, pix_x}, {1'b0, org_x}, 11'(IMG_W)) &&
               in_span({1'b0, pix_y}, {1'b0, org_y}, 11'(IMG_H));

  // Next address: frame_end restarts the image even if this pixel is a hit.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    cnt_nxt = addr_cnt;
    if (frame_end) begin
      cnt_nxt = '0;
    end else if (hit) begin
      cnt_nxt = (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
    end
  end

  // Issue the ROM read for the current pixel and advance the address counter.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rom.rom_rd_en <= 1'b0;
      rom.rom_addr  <= '0;
      addr_cnt      <= '0;
    end else begin
      rom.rom_rd_en <= hit;
      rom.rom_addr  <= addr_cnt;
      addr_cnt      <= cnt_nxt;
    end
  end

  // Carry hit alongside the ROM access so it lines up with rom_data.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      hit_pipe <= '0;
    end else begin
      hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit};
    end
  end

  assign hit_d = hit_pipe[ROM_LAT];

  // Registered pixel mux: image data inside the window, background elsewhere.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rgb <= '0;
    end else begin
      rgb <= hit_d ? rom.rom_data : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_img_window_ctrl.sv
// Self-checking bench for vga_img_window_ctrl: table-driven address vectors,
// a windowed frame scan with rgb alignment, frame_end/hit collision, mid-frame
// reset, and either the bounce walk (VGA_IMG_BOUNCE_EN) or the fixed origin.
module tb_vga_img_window_ctrl;
  import vga_img_pkg::*;

  localparam int      IMG_W   = 100;
  localparam int      IMG_H   = 100;
  localparam int      ADDR_W  = 14;
  localparam int      ROM_LAT = 1;
  localparam rgb565_t BG      = 16'h0000;
  localparam rgb565_t NO_READ = 16'h5A5A;
`ifdef VGA_IMG_BOUNCE_EN
  localparam int OX0 = 0;
  localparam int OY0 = 0;
`else
  localparam int OX0 = 270;
  localparam int OY0 = 190;
`endif

  logic       sys_clk;
  logic       rst_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic       frame_end;
  rgb565_t    rgb;

  vga_img_window_ctrl_if #(.ADDR_W(ADDR_W)) rom_if ();

  vga_img_window_ctrl #(.ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .BG_COLOR(BG)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .frame_end (frame_end),
    .rom       (rom_if),
    .rgb       (rgb)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  function automatic rgb565_t rom_word(input int a);
    return 16'h8000 | 16'(a);
  endfunction

  // ROM model: data for a read appears ROM_LAT cycles after rom_rd_en.
  rgb565_t rom_pipe [ROM_LAT];
  always @(posedge sys_clk) begin
    rom_pipe[0] <= rom_if.rom_rd_en ? rom_word(int'(rom_if.rom_addr)) : NO_READ;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_if.rom_data = rom_pipe[ROM_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_ox   = OX0;
  int cur_oy   = OY0;
  bit chk_rgb  = 1'b0;
  int rgb_err  = 0;
  rgb565_t exp_hist [ROM_LAT+2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic bit in_win(input int x, input int y, input bit valid);
    return valid && (x >= cur_ox) && (x < cur_ox + IMG_W) &&
           (y >= cur_oy) && (y < cur_oy + IMG_H);
  endfunction

  // Drive one pixel, clock it in, and track the expected rgb stream.
  task automatic step(input int x, input int y, input bit valid, input bit fe);
    bit in_reset;
    in_reset  = !rst_n;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = valid;
    frame_end = fe;
    @(posedge sys_clk);
    #1;
    if (in_reset) begin
      foreach (exp_hist[i]) exp_hist[i] = BG;
    end else begin
      for (int i = ROM_LAT + 1; i > 0; i--) exp_hist[i] = exp_hist[i-1];
      exp_hist[0] = in_win(x, y, valid) ?
                    rom_word((y - cur_oy) * IMG_W + (x - cur_ox)) : BG;
    end
    if (chk_rgb && rgb !== exp_hist[ROM_LAT+1]) rgb_err++;
  endtask

  task automatic probe(input string name, input int x, input int y, input bit fe,
                       input bit exp_en, input int exp_addr);
    step(x, y, 1'b1, fe);
    check({name, "_en"}, 32'(rom_if.rom_rd_en), 32'(exp_en));
    if (exp_en) check({name, "_addr"}, 32'(rom_if.rom_addr), 32'(exp_addr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cur_ox = OX0;
    cur_oy = OY0;
  endtask

  typedef struct {
    int rx;
    int ry;
    bit valid;
    bit fe;
    bit chk;
    bit exp_en;
    int exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rx, input int ry, input bit valid, input bit fe,
                              input bit chk, input bit exp_en, input int exp_addr);
    vec_t v;
    v.rx = rx; v.ry = ry; v.valid = valid; v.fe = fe;
    v.chk = chk; v.exp_en = exp_en; v.exp_addr = exp_addr;
    return v;
  endfunction

  initial begin
    int rd_cnt, last_addr, scan_err, x_lo, x_hi, y_lo, y_hi;
    bit exp_en;

    // Vectors relative to the window origin, applied right after reset.
    for (int rx = 0; rx < IMG_W; rx++)
      vecs.push_back(mk(rx, 0, 1'b1, 1'b0, (rx == 0) || (rx == IMG_W - 1), 1'b1, rx));
    vecs.push_back(mk(IMG_W, 0,     1'b1, 1'b0, 1'b1, 1'b0, 0));
    vecs.push_back(mk(0,     1,     1'b1, 1'b0, 1'b1, 1'b1, 100));
    vecs.push_back(mk(1,     1,     1'b0, 1'b0, 1'b1, 1'b0, 0));
    vecs.push_back(mk(1,     1,     1'b1, 1'b0, 1'b1, 1'b1, 101));
    vecs.push_back(mk(0,     IMG_H, 1'b1, 1'b0, 1'b1, 1'b0, 0));
    vecs.push_back(mk(2,     1,     1'b1, 1'b0, 1'b1, 1'b1, 102));

    rst_n = 1'b0;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_end = 1'b0;
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("reset_rd_en", 32'(rom_if.rom_rd_en), 0);
    check("reset_addr",  32'(rom_if.rom_addr),  0);
    check("reset_rgb",   32'(rgb),              0);

    // Test 1: table-driven address sequencing.
    foreach (vecs[i]) begin
      step(cur_ox + vecs[i].rx, cur_oy + vecs[i].ry, vecs[i].valid, vecs[i].fe);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_en", i), 32'(rom_if.rom_rd_en), 32'(vecs[i].exp_en));
        if (vecs[i].exp_en)
          check($sformatf("vec%0d_addr", i), 32'(rom_if.rom_addr), 32'(vecs[i].exp_addr));
      end
    end

    // Test 2: one frame over the window neighbourhood with rgb alignment.
    do_reset();
    chk_rgb = 1'b1;
    rgb_err = 0; rd_cnt = 0; last_addr = -1; scan_err = 0;
    x_lo = (cur_ox >= 2) ? cur_ox - 2 : 0;
    x_hi = cur_ox + IMG_W + 1;
    y_lo = (cur_oy >= 1) ? cur_oy - 1 : 0;
    y_hi = cur_oy + IMG_H;
    for (int y = y_lo; y <= y_hi; y++) begin
      for (int x = x_lo; x <= x_hi; x++) begin
        step(x, y, 1'b1, 1'b0);
        exp_en = in_win(x, y, 1'b1);
        if (rom_if.rom_rd_en !== exp_en) scan_err++;
        if (rom_if.rom_rd_en === 1'b1) begin
          rd_cnt++;
          last_addr = int'(rom_if.rom_addr);
          if (exp_en && last_addr != (y - cur_oy) * IMG_W + (x - cur_ox)) scan_err++;
        end
      end
      step(0, 0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < ROM_LAT + 2; i++) step(0, 0, 1'b0, 1'b0);
    chk_rgb = 1'b0;
    check("frame_rd_cnt",    32'(rd_cnt),    10000);
    check("frame_last_addr", 32'(last_addr), 9999);
    check("frame_addr_err",  32'(scan_err),  0);
    check("frame_rgb_err",   32'(rgb_err),   0);
    step(0, 0, 1'b0, 1'b1);
`ifdef VGA_IMG_BOUNCE_EN
    cur_ox = 1; cur_oy = 1;
`endif
    probe("restart", cur_ox, cur_oy, 1'b0, 1'b1, 0);
    step(0, 0, 1'b0, 1'b0);
    check("rgb_lat_early", 32'(rgb), 32'(BG));
    step(0, 0, 1'b0, 1'b0);
    check("rgb_lat_hit",   32'(rgb), 32'(rom_word(0)));

    // Test 4: frame_end coincident with a hit at counter 57.
    for (int rx = 1; rx < 57; rx++) step(cur_ox + rx, cur_oy, 1'b1, 1'b0);
    probe("fe_hit", cur_ox + 57, cur_oy, 1'b1, 1'b1, 57);
`ifdef VGA_IMG_BOUNCE_EN
    cur_ox = 2; cur_oy = 2;
`endif
    probe("after_fe0", cur_ox,     cur_oy, 1'b0, 1'b1, 0);
    probe("after_fe1", cur_ox + 1, cur_oy, 1'b0, 1'b1, 1);

    // Test 5: reset for one cycle in mid-window at address 4321.
    for (int k = 2; k < 4321; k++) step(cur_ox + k % IMG_W, cur_oy + k / IMG_W, 1'b1, 1'b0);
    probe("pre_rst", cur_ox + 4321 % IMG_W, cur_oy + 4321 / IMG_W, 1'b0, 1'b1, 4321);
    rst_n = 1'b0;
    step(cur_ox + 4322 % IMG_W, cur_oy + 4322 / IMG_W, 1'b1, 1'b0);
    rst_n = 1'b1;
    cur_ox = OX0; cur_oy = OY0;
    check("midrst_rd_en", 32'(rom_if.rom_rd_en), 0);
    check("midrst_addr",  32'(rom_if.rom_addr),  0);
    check("midrst_rgb",   32'(rgb),              0);
    probe("post_rst", cur_ox, cur_oy, 1'b0, 1'b1, 0);

`ifdef VGA_IMG_BOUNCE_EN
    // Test 3: bounce at the right edge and the top edge.
    repeat (539) step(0, 0, 1'b0, 1'b1);
    probe("x539_l",  538, 221, 1'b0, 1'b0, 0);
    probe("x539_t",  539, 220, 1'b0, 1'b0, 0);
    probe("x539_in", 539, 221, 1'b0, 1'b1, 0);
    step(0, 0, 1'b0, 1'b1);
    probe("x540_l",  539, 220, 1'b0, 1'b0, 0);
    probe("x540_in", 540, 220, 1'b0, 1'b1, 0);
    probe("x540_re", 639, 220, 1'b0, 1'b1, 1);
    step(0, 0, 1'b0, 1'b1);
    probe("xneg_l",  538, 219, 1'b0, 1'b0, 0);
    probe("xneg_in", 539, 219, 1'b0, 1'b1, 0);
    repeat (218) step(0, 0, 1'b0, 1'b1);
    probe("y1_t",  321, 0, 1'b0, 1'b0, 0);
    probe("y1_l",  320, 1, 1'b0, 1'b0, 0);
    probe("y1_in", 321, 1, 1'b0, 1'b1, 0);
    step(0, 0, 1'b0, 1'b1);
    probe("y0_l",  319, 0, 1'b0, 1'b0, 0);
    probe("y0_in", 320, 0, 1'b0, 1'b1, 0);
    step(0, 0, 1'b0, 1'b1);
    probe("ypos_t",  319, 0, 1'b0, 1'b0, 0);
    probe("ypos_in", 319, 1, 1'b0, 1'b1, 0);
`else
    // Test 6: origin stays at (270,190) across frames.
    for (int f = 0; f < 3; f++) begin
      step(0, 0, 1'b0, 1'b1);
      probe($sformatf("f%0d_left", f),  269, 190, 1'b0, 1'b0, 0);
      probe($sformatf("f%0d_above", f), 270, 189, 1'b0, 1'b0, 0);
      probe($sformatf("f%0d_right", f), 370, 190, 1'b0, 1'b0, 0);
      probe($sformatf("f%0d_below", f), 270, 290, 1'b0, 1'b0, 0);
      probe($sformatf("f%0d_first", f), 270, 190, 1'b0, 1'b1, 0);
      probe($sformatf("f%0d_corner", f), 369, 289, 1'b0, 1'b1, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
